// File: rtl/crc16_serial_arb.sv
// Two-requester round-robin front end feeding a bit-serial CRC-16 (poly 0x1021, MSB first).
// Define CRC16_ARB_SEED_ONES_EN to seed the CRC with 16'hFFFF instead of 16'h0000.
module crc16_serial_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_crc,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam int DATA_W = 32;
    localparam int CRC_W  = 16;
    localparam logic [CRC_W-1:0] POLY = 16'h1021;
`ifdef CRC16_ARB_SEED_ONES_EN
    localparam logic [CRC_W-1:0] SEED = 16'hFFFF;
`else
    localparam logic [CRC_W-1:0] SEED = 16'h0000;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CRC_W-1:0]  crc;
    logic [4:0]        cnt;
    logic              last;
    logic              grant0;
    logic              grant1;
    logic              accept;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = b ^ c[CRC_W-1];
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
    endfunction

    // On contention the requester not served last wins; 'last' resets to 1 so requester 0 wins first.
    assign grant0     = req0_valid & (~req1_valid | last);
    assign grant1     = req1_valid & (~req0_valid | ~last);
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;
    assign rsp_crc    = crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            crc       <= '0;
            cnt       <= '0;
            rsp_id    <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg  <= req1_ready ? req1_data : req0_data;
                        crc    <= SEED;
                        cnt    <= '0;
                        rsp_id <= req1_ready;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc   <= crc_step(crc, shreg[DATA_W-1]);
                    shreg <= {shreg[DATA_W-2:0], 1'b0};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        last      <= rsp_id;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_serial_arb.sv
// Randomized self-checking bench for crc16_serial_arb against a polynomial-division CRC model.
module tb_crc16_serial_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [15:0] rsp_crc;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef CRC16_ARB_SEED_ONES_EN
    localparam logic [15:0] SEED = 16'hFFFF;
`else
    localparam logic [15:0] SEED = 16'h0000;
`endif

    bit          pend_v[2];
    logic [31:0] pend_d[2];
    logic        last_m;
    logic [15:0] got_crc;

    crc16_serial_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_crc(rsp_crc),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of (seed*x^32 + data*x^16) mod (x^16 + x^12 + x^5 + 1)
    function automatic logic [15:0] crc_ref(input logic [31:0] d, input logic [15:0] s);
        logic [47:0] v;
        v = {s, 32'h0} ^ {16'h0, d, 16'h0};
        for (int i = 47; i >= 16; i--)
            if (v[i]) v = v ^ (48'h11021 << (i - 16));
        return v[15:0];
    endfunction

    task automatic drive_reqs();
        req0_valid = pend_v[0];
        req0_data  = pend_d[0];
        req1_valid = pend_v[1];
        req1_data  = pend_d[1];
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge after the rsp handshake.
    task automatic transact(input int hold);
        int          n;
        bit          g;
        logic [31:0] d;
        logic [15:0] c;
        rsp_ready = (hold == 0);
        drive_reqs();
        #1;
        g = (pend_v[0] && pend_v[1]) ? !last_m : pend_v[1];
        chk("ready0", req0_ready, pend_v[0] && !g);
        chk("ready1", req1_ready, pend_v[1] && g);
        d = pend_d[g];
        @(posedge clk);
        @(negedge clk);
        pend_v[g] = 0;
        drive_reqs();
        #1;
        chk("busy_shift", busy, 1'b1);
        chk("ready_shift", {req1_ready, req0_ready}, 2'b00);
        n = 1;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", n, 33);
        chk("rsp_id", rsp_id, g);
        chk("rsp_crc", rsp_crc, crc_ref(d, SEED));
        c = rsp_crc;
        got_crc = c;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_crc", rsp_crc, c);
            chk("hold_ready", {req1_ready, req0_ready}, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
        last_m = g;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        pend_v[0] = 0; pend_v[1] = 0;
        pend_d[0] = '0; pend_d[1] = '0;
        last_m = 1'b1;
        drive_reqs();
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_crc", rsp_crc, 16'h0000);
        chk("rst_id", rsp_id, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        pend_v[0] = 1; pend_d[0] = 32'h00000001;
        transact(0);
`ifndef CRC16_ARB_SEED_ONES_EN
        chk("crc_0001", got_crc, 16'h1021);
`endif
        pend_v[1] = 1; pend_d[1] = 32'h00000002;
        transact(0);
`ifndef CRC16_ARB_SEED_ONES_EN
        chk("crc_0002", got_crc, 16'h2042);
`endif
        pend_v[1] = 1; pend_d[1] = 32'h00000000;
        transact(0);
`ifndef CRC16_ARB_SEED_ONES_EN
        chk("crc_0000", got_crc, 16'h0000);
`else
        chk("seed_diff", got_crc != crc_ref(32'h0, 16'h0000), 1'b1);
`endif

        // A valid that drops before any edge must not start a word.
        req1_valid = 1'b1;
        req1_data  = $urandom;
        #1;
        chk("drop_ready", req1_ready, 1'b1);
        #2;
        req1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_busy", busy, 1'b0);

        // Continuous contention: grants must alternate.
        pend_v[0] = 1; pend_d[0] = $urandom;
        pend_v[1] = 1; pend_d[1] = $urandom;
        for (int k = 0; k < 6; k++) begin
            transact((k == 2) ? 10 : 0);
            chk("alt_id", last_m, k[0]);
            for (int r = 0; r < 2; r++)
                if (!pend_v[r]) begin pend_v[r] = 1; pend_d[r] = $urandom; end
        end

        // Reset in the middle of SHIFT aborts the word.
        pend_v[1] = 0;
        drive_reqs();
        @(posedge clk);
        @(negedge clk);
        pend_v[0] = 0;
        drive_reqs();
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_m = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("no_retry_valid", rsp_valid, 1'b0);
        chk("no_retry_busy", busy, 1'b0);
        pend_v[0] = 1; pend_d[0] = $urandom;
        pend_v[1] = 1; pend_d[1] = $urandom;
        transact(0);
        chk("post_rst_id", last_m, 1'b0);

        for (int k = 0; k < 20; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pend_v[r] && $urandom_range(0, 1)) begin pend_v[r] = 1; pend_d[r] = $urandom; end
            if (!pend_v[0] && !pend_v[1]) begin pend_v[0] = 1; pend_d[0] = $urandom; end
            transact($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
